// File: rtl/axis_throttler_if.sv
// ----------------------------------------------------------------------------
// axis_throttler_if
//  Minimal AXI4-Stream bundle (tvalid / tready / tdata) used on both sides of
//  the throttler.
//  Parameter:
//   AXIS_TDATA_WIDTH  width of tdata in bits
//  Signals:
//   tvalid  beat valid, driven by the master
//   tready  beat accepted when tvalid & tready, driven by the slave
//   tdata   beat payload, driven by the master
//  Modports:
//   master  drives tvalid/tdata, observes tready
//   slave   observes tvalid/tdata, drives tready
// ----------------------------------------------------------------------------
interface axis_throttler_if #(
   parameter int AXIS_TDATA_WIDTH = 32
);
   logic                        tvalid;
   logic                        tready;
   logic [AXIS_TDATA_WIDTH-1:0] tdata;

   modport master (
      output tvalid,
      output tdata,
      input  tready
   );

   modport slave (
      input  tvalid,
      input  tdata,
      output tready
   );
endinterface

// File: rtl/axis_throttler.sv
// ----------------------------------------------------------------------------
// axis_throttler
//  AXI4-Stream decimator. Of every group of 2^log_throttle accepted input
//  beats, one output beat is produced one clock after the last beat of the
//  group is accepted. The output stage is a single register with full
//  tvalid/tready flow control; input is stalled while that register holds a
//  beat the consumer has not taken.
//
//  Build option:
//   AXIS_THROTTLER_AVG_EN  when defined, the output beat is the signed mean
//                          of the group (sum >>> N) instead of its last beat.
//
//  Parameter:
//   AXIS_TDATA_WIDTH  payload width (must match both interfaces)
//  Ports:
//   aclk          rising-edge clock
//   aresetn       asynchronous active-low reset
//   log_throttle  decimation exponent N, ratio = 2^N (0..31)
//   S_AXIS        input stream  (slave modport)
//   M_AXIS        output stream (master modport), registered
// ----------------------------------------------------------------------------
module axis_throttler #(
   parameter int AXIS_TDATA_WIDTH = 32
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic [4:0]             log_throttle,
   axis_throttler_if.slave        S_AXIS,
   axis_throttler_if.master       M_AXIS
);

   localparam int W = AXIS_TDATA_WIDTH;

   logic [4:0]   log_shadow;
   logic [31:0]  cnt;
   logic [31:0]  cnt_eff;
   logic [31:0]  group_mask;
   logic         rate_change;
   logic         s_ready;
   logic         accept;
   logic         group_last;
   logic         m_valid;
   logic [W-1:0] m_data;
   logic [W-1:0] load_data;

   // Input is taken whenever the output register is empty or being drained
   // this cycle; held off entirely while in reset.
   assign s_ready       = aresetn & (~m_valid | M_AXIS.tready);
   assign S_AXIS.tready = s_ready;
   assign M_AXIS.tvalid = m_valid;
   assign M_AXIS.tdata  = m_data;

   // A rate change restarts the group in the same cycle, so a beat accepted
   // alongside the change is index 0 of a group sized by the new exponent.
   // The mask form 2^N-1 stays inside 32 bits even for N=31.
   always_comb begin
      rate_change = (log_throttle != log_shadow);
      cnt_eff     = rate_change ? 32'd0 : cnt;
      group_mask  = ~(32'hFFFF_FFFF << log_throttle);
      accept      = S_AXIS.tvalid & s_ready;
      group_last  = accept && (cnt_eff == group_mask);
   end

`ifdef AXIS_THROTTLER_AVG_EN
   localparam int AW = W + 32;

   logic signed [AW-1:0] acc;
   logic signed [AW-1:0] acc_eff;
   logic signed [AW-1:0] acc_sum;
   logic signed [AW-1:0] acc_mean;

   // Running signed sum of the group; the last beat is folded in
   // combinationally so the mean is available on the loading edge.
   always_comb begin
      acc_eff   = rate_change ? '0 : acc;
      acc_sum   = acc_eff + $signed({{32{S_AXIS.tdata[W-1]}}, S_AXIS.tdata});
      acc_mean  = acc_sum >>> log_throttle;
      load_data = acc_mean[W-1:0];
   end

   // Accumulator restarts after each completed group and on rate change.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         acc <= '0;
      end else if (group_last) begin
         acc <= '0;
      end else if (accept) begin
         acc <= acc_sum;
      end else begin
         acc <= acc_eff;
      end
   end
`else
   // Selection mode: the last beat of each group is forwarded unchanged.
   always_comb begin
      load_data = S_AXIS.tdata;
   end
`endif

   // Beat counter and exponent shadow. Gaps in tvalid leave the count alone.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cnt        <= 32'd0;
         log_shadow <= 5'd0;
      end else begin
         log_shadow <= log_throttle;
         if (group_last) begin
            cnt <= 32'd0;
         end else if (accept) begin
            cnt <= cnt_eff + 32'd1;
         end else begin
            cnt <= cnt_eff;
         end
      end
   end

   // Output register. A new load wins over a drain in the same cycle, so
   // tvalid stays high and the payload is replaced. Data is only written on
   // a load, so it holds steady while the consumer stalls.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         m_valid <= 1'b0;
         m_data  <= '0;
      end else if (group_last) begin
         m_valid <= 1'b1;
         m_data  <= load_data;
      end else if (M_AXIS.tready) begin
         m_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axis_throttler.sv
// ----------------------------------------------------------------------------
// tb_axis_throttler
//  Directed self-checking bench for axis_throttler. Each table row is one
//  clock: inputs are driven just after a rising edge, S_AXIS_tready is
//  checked mid-cycle, and M_AXIS tvalid/tdata are checked just after the next
//  rising edge. Reset behaviour is exercised by hand-written sequences.
//  Build option AXIS_THROTTLER_AVG_EN switches the expected payloads to the
//  group mean and adds the averaging vectors.
// ----------------------------------------------------------------------------
module tb_axis_throttler;

   localparam int W = 32;

`ifdef AXIS_THROTTLER_AVG_EN
   localparam logic [31:0] T3_OUT1 = 32'd11;
   localparam logic [31:0] T3_OUT2 = 32'd15;
   localparam logic [31:0] T4_OUT  = 32'd22;
   localparam logic [31:0] GAP_OUT = 32'd30;
   localparam logic [31:0] T5_OUT  = 32'd303;
`else
   localparam logic [31:0] T3_OUT1 = 32'd13;
   localparam logic [31:0] T3_OUT2 = 32'd17;
   localparam logic [31:0] T4_OUT  = 32'd23;
   localparam logic [31:0] GAP_OUT = 32'd31;
   localparam logic [31:0] T5_OUT  = 32'd307;
`endif

   logic       aclk;
   logic       aresetn;
   logic [4:0] log_throttle;

   axis_throttler_if #(.AXIS_TDATA_WIDTH(W)) s_axis ();
   axis_throttler_if #(.AXIS_TDATA_WIDTH(W)) m_axis ();

   axis_throttler #(.AXIS_TDATA_WIDTH(W)) dut (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .log_throttle (log_throttle),
      .S_AXIS       (s_axis),
      .M_AXIS       (m_axis)
   );

   typedef struct {
      logic [4:0]  lg;
      logic        tv;
      logic [31:0] td;
      logic        mr;
      logic        exp_sr;
      logic        exp_mv;
      logic [31:0] exp_md;
   } vec_t;

   vec_t vecs[$];
   int   num_compared;
   int   num_mismatched;

   // 10 ns clock
   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   function automatic vec_t mk(input logic [4:0] lg, input logic tv, input logic [31:0] td,
                               input logic mr, input logic esr, input logic emv,
                               input logic [31:0] emd);
      vec_t r;
      r.lg = lg; r.tv = tv; r.td = td; r.mr = mr;
      r.exp_sr = esr; r.exp_mv = emv; r.exp_md = emd;
      return r;
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      num_compared++;
      if (act !== exp) begin
         num_mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply_stimulus(input vec_t r);
      log_throttle  = r.lg;
      s_axis.tvalid = r.tv;
      s_axis.tdata  = r.td;
      m_axis.tready = r.mr;
   endtask

   // One clock: called at posedge+1, returns at the following posedge+1.
   task automatic run_row(input vec_t r, input string tag);
      apply_stimulus(r);
      #3;
      check_output({tag, " s_tready"}, {31'd0, s_axis.tready}, {31'd0, r.exp_sr});
      @(posedge aclk);
      #1;
      check_output({tag, " m_tvalid"}, {31'd0, m_axis.tvalid}, {31'd0, r.exp_mv});
      check_output({tag, " m_tdata"}, m_axis.tdata, r.exp_md);
   endtask

   // Asserts reset mid-cycle, checks the async clear, releases at posedge+1.
   task automatic pulse_reset(input string tag);
      #2;
      aresetn = 1'b0;
      #1;
      check_output({tag, " rst m_tvalid"}, {31'd0, m_axis.tvalid}, 32'd0);
      check_output({tag, " rst m_tdata"}, m_axis.tdata, 32'd0);
      check_output({tag, " rst s_tready"}, {31'd0, s_axis.tready}, 32'd0);
      @(posedge aclk);
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
   endtask

   initial begin
      num_compared   = 0;
      num_mismatched = 0;

      // ---- vector table ----
      // T1: N=3, ten beats of 2; only the 8th produces an output
      for (int i = 0; i < 10; i++)
         vecs.push_back(mk(5'd3, 1'b1, 32'd2, 1'b1, 1'b1, (i == 7), (i >= 7) ? 32'd2 : 32'd0));
      // T2: N=0 pass-through, no bubbles
      for (int k = 1; k <= 4; k++)
         vecs.push_back(mk(5'd0, 1'b1, k, 1'b1, 1'b1, 1'b1, k));
      vecs.push_back(mk(5'd0, 1'b0, 32'hDEAD, 1'b1, 1'b1, 1'b0, 32'd4));
      // T3: N=2, beats 10..17 with a 5-cycle output stall after the first result
      for (int k = 10; k <= 12; k++)
         vecs.push_back(mk(5'd2, 1'b1, k, 1'b1, 1'b1, 1'b0, 32'd4));
      vecs.push_back(mk(5'd2, 1'b1, 32'd13, 1'b1, 1'b1, 1'b1, T3_OUT1));
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(5'd2, 1'b1, 32'd14, 1'b0, 1'b0, 1'b1, T3_OUT1));
      for (int k = 14; k <= 16; k++)
         vecs.push_back(mk(5'd2, 1'b1, k, 1'b1, 1'b1, 1'b0, T3_OUT1));
      vecs.push_back(mk(5'd2, 1'b1, 32'd17, 1'b1, 1'b1, 1'b1, T3_OUT2));
      vecs.push_back(mk(5'd2, 1'b0, 32'hDEAD, 1'b1, 1'b1, 1'b0, T3_OUT2));
      // T4: two beats at N=2, switch to N=1, next pair yields its 2nd beat
      vecs.push_back(mk(5'd2, 1'b1, 32'd20, 1'b1, 1'b1, 1'b0, T3_OUT2));
      vecs.push_back(mk(5'd2, 1'b1, 32'd21, 1'b1, 1'b1, 1'b0, T3_OUT2));
      vecs.push_back(mk(5'd1, 1'b0, 32'hDEAD, 1'b1, 1'b1, 1'b0, T3_OUT2));
      vecs.push_back(mk(5'd1, 1'b1, 32'd22, 1'b1, 1'b1, 1'b0, T3_OUT2));
      vecs.push_back(mk(5'd1, 1'b1, 32'd23, 1'b1, 1'b1, 1'b1, T4_OUT));
      vecs.push_back(mk(5'd1, 1'b0, 32'hDEAD, 1'b1, 1'b1, 1'b0, T4_OUT));
      // tvalid gaps do not advance the group
      vecs.push_back(mk(5'd1, 1'b1, 32'd30, 1'b1, 1'b1, 1'b0, T4_OUT));
      vecs.push_back(mk(5'd1, 1'b0, 32'hDEAD, 1'b1, 1'b1, 1'b0, T4_OUT));
      vecs.push_back(mk(5'd1, 1'b0, 32'hDEAD, 1'b1, 1'b1, 1'b0, T4_OUT));
      vecs.push_back(mk(5'd1, 1'b1, 32'd31, 1'b1, 1'b1, 1'b1, GAP_OUT));
      vecs.push_back(mk(5'd1, 1'b0, 32'hDEAD, 1'b1, 1'b1, 1'b0, GAP_OUT));
      // N=31: a few beats never complete a group
      for (int i = 0; i < 3; i++)
         vecs.push_back(mk(5'd31, 1'b1, 32'd5, 1'b1, 1'b1, 1'b0, GAP_OUT));

      // ---- reset state ----
      aresetn       = 1'b0;
      log_throttle  = 5'd3;
      s_axis.tvalid = 1'b0;
      s_axis.tdata  = '0;
      m_axis.tready = 1'b1;
      repeat (3) @(posedge aclk);
      #1;
      check_output("reset m_tvalid", {31'd0, m_axis.tvalid}, 32'd0);
      check_output("reset m_tdata", m_axis.tdata, 32'd0);
      check_output("reset s_tready", {31'd0, s_axis.tready}, 32'd0);
      aresetn = 1'b1;

      // ---- table ----
      for (int i = 0; i < vecs.size(); i++)
         run_row(vecs[i], $sformatf("row%0d", i));

      // ---- reset mid-group: 5 beats in, then 8 fresh beats needed ----
      for (int k = 1; k <= 5; k++)
         run_row(mk(5'd3, 1'b1, k, 1'b1, 1'b1, 1'b0, GAP_OUT), $sformatf("mid%0d", k));
      pulse_reset("midgroup");
      for (int k = 300; k <= 306; k++)
         run_row(mk(5'd3, 1'b1, k, 1'b1, 1'b1, 1'b0, 32'd0), $sformatf("post%0d", k));
      run_row(mk(5'd3, 1'b1, 32'd307, 1'b1, 1'b1, 1'b1, T5_OUT), "post307");

      // ---- reset while an output beat is stalled ----
      run_row(mk(5'd3, 1'b0, 32'hDEAD, 1'b0, 1'b0, 1'b1, T5_OUT), "pend hold");
      pulse_reset("pending");
      run_row(mk(5'd3, 1'b0, 32'hDEAD, 1'b1, 1'b1, 1'b0, 32'd0), "pend after");

`ifdef AXIS_THROTTLER_AVG_EN
      // ---- averaging: mean of signed groups ----
      run_row(mk(5'd2, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 32'd0), "avg a0");
      run_row(mk(5'd2, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0, 32'd0), "avg a1");
      run_row(mk(5'd2, 1'b1, 32'd2, 1'b1, 1'b1, 1'b0, 32'd0), "avg a2");
      run_row(mk(5'd2, 1'b1, 32'd8, 1'b1, 1'b1, 1'b1, 32'd1), "avg a3");
      for (int i = 0; i < 3; i++)
         run_row(mk(5'd2, 1'b1, 32'd4, 1'b1, 1'b1, 1'b0, 32'd1), $sformatf("avg b%0d", i));
      run_row(mk(5'd2, 1'b1, 32'd4, 1'b1, 1'b1, 1'b1, 32'd4), "avg b3");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
      $finish;
   end

endmodule
